// File: rtl/div.sv
// div: sequential restoring divider, 16-bit / 8-bit unsigned, one quotient bit per clock, 17-cycle latency.
module div (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] a_bi,
  input  logic [7:0]  b_bi,
  input  logic        start_i,
  output logic        busy_o,
  output logic [15:0] y_bo,
  output logic [7:0]  r_bo,
  output logic        dbz_o
);
  typedef enum logic {IDLE, WORK} state_t;
  state_t state, state_nx;
  logic [15:0] dvd, quo;
  logic [7:0]  dsr, rem, lo;
  logic [4:0]  ctr;
  logic [8:0]  t;
  logic        ge, last;
  always_comb begin
    t = {rem, dvd[15]};
    ge = t >= {1'b0, dsr};
    last = ctr == 5'd16;
    state_nx = state == IDLE ? (start_i ? WORK : IDLE) : (last ? IDLE : WORK);
  end
  assign busy_o = state == WORK;
  // rem < dsr after every step, so the 8-bit modular difference is exact
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      dvd   <= '0;
      quo   <= '0;
      dsr   <= '0;
      rem   <= '0;
      lo    <= '0;
      ctr   <= '0;
      y_bo  <= '0;
      r_bo  <= '0;
      dbz_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start_i) begin
        dvd <= a_bi;
        dsr <= b_bi;
        lo  <= a_bi[7:0];
        quo <= '0;
        rem <= '0;
        ctr <= '0;
      end else if (state == WORK && !last) begin
        dvd <= {dvd[14:0], 1'b0};
        rem <= ge ? t[7:0] - dsr : t[7:0];
        quo <= {quo[14:0], ge};
        ctr <= ctr + 5'd1;
      end else if (state == WORK) begin
        y_bo  <= dsr == 8'd0 ? 16'hFFFF : quo;
        r_bo  <= dsr == 8'd0 ? lo : rem;
        dbz_o <= dsr == 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed checks of div against an arithmetic reference model.
module tb_div;
  logic        clk = 1'b0, rst, start, busy, dbz;
  logic [15:0] a, y;
  logic [7:0]  b, r;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  div dut (
    .clk_i(clk), .rst_i(rst), .a_bi(a), .b_bi(b), .start_i(start),
    .busy_o(busy), .y_bo(y), .r_bo(r), .dbz_o(dbz)
  );
  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // noisy: scramble operands and pulse start at busy cycles 5 and 17; rst_at: abort at that busy cycle
  task automatic op(input logic [15:0] av, input logic [7:0] bv, input bit noisy, input int rst_at);
    int n;
    logic [15:0] ey;
    logic [7:0]  er;
    logic        ed;
    if (bv == 8'd0) begin
      ey = 16'hFFFF; er = av[7:0]; ed = 1'b1;
    end else begin
      ey = av / {8'd0, bv}; er = 8'(av % {8'd0, bv}); ed = 1'b0;
    end
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_y", y, 0);
        chk("abort_r", r, 0);
        chk("abort_dbz", dbz, 0);
        return;
      end
      if (noisy) begin
        start = n == 5 || n == 17;
        a = start ? 16'h0001 : 16'($urandom);
        b = start ? 8'h01 : 8'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_len", n, 17);
    chk("quotient", y, ey);
    chk("remainder", r, er);
    chk("dbz", dbz, ed);
    if (noisy) begin
      @(negedge clk);
      chk("no_restart", busy, 0);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk("hold_y", y, ey);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);
    chk("rst_r", r, 0);
    chk("rst_dbz", dbz, 0);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      a = 16'($urandom); b = 8'($urandom);
    end
    chk("idle_busy", busy, 0);
    chk("idle_y", y, 0);
    chk("idle_r", r, 0);
    op(16'h03E8, 8'h07, 0, 0);
    op(16'h000C, 8'h0D, 0, 0);
    op(16'hFFFF, 8'h01, 0, 0);
    op(16'hFFFF, 8'hFF, 0, 0);
    op(16'hFFFE, 8'hFF, 0, 0);
    op(16'h1234, 8'h00, 0, 0);
    op(16'h0064, 8'h0A, 0, 0);
    op(16'h0064, 8'h03, 1, 0);
    op(16'h03E8, 8'h07, 0, 8);
    op(16'h0010, 8'h04, 0, 0);
    for (int i = 0; i < 40; i++)
      op(16'($urandom), $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom), i % 4 == 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
